// File: rtl/mod_n_counter.sv
// Modulo-N up counter (optional up/down via MOD_N_COUNTER_DOWN_EN) with parallel load and terminal-count flag.
// Latency: q updates one clk edge after load/en change; tc is combinational from q.
// Backpressure: none; en stalls the count and load takes priority over en.
module mod_n_counter #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
`ifdef MOD_N_COUNTER_DOWN_EN
    input  logic             up_dn,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Last legal count. N may equal 2**WIDTH, so N itself is held one bit wider.
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(N - 1);
    localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic             count_up;
    logic             load_ok;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;

`ifdef MOD_N_COUNTER_DOWN_EN
    assign count_up = up_dn;
`else
    assign count_up = 1'b1;
`endif

    // Out-of-range load values are forced to zero so q never leaves 0..N-1.
    assign load_ok = ({1'b0, d} < N_EXT);

    // Next-count candidates; wrap is an explicit compare, never natural overflow.
    always_comb begin
        q_inc = (q == LAST) ? '0 : q + ONE;
        q_dec = (q == '0) ? LAST : q - ONE;
    end

    // Terminal count is the last value in the current direction of travel.
    assign tc = count_up ? (q == LAST) : (q == '0);

    // Count register: async clear, then load > enable > hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_ok ? d : '0;
        end else if (en) begin
            q <= count_up ? q_inc : q_dec;
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter (N=10, WIDTH=4): directed steps plus randomized traffic.
// Reference model is plain modulo arithmetic on an integer count.
// Outputs are sampled 1 ns after each rising edge; inputs change away from the edge.
module tb_mod_n_counter;

    localparam int N     = 10;
    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             dir_up;
    logic [WIDTH-1:0] q;
    logic             tc;

    int checks;
    int errors;
    int mq;

    mod_n_counter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
`ifdef MOD_N_COUNTER_DOWN_EN
        .up_dn (dir_up),
`endif
        .load  (load),
        .d     (d),
        .q     (q),
        .tc    (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_tc(input int v);
        return dir_up ? int'(v == N - 1) : int'(v == 0);
    endfunction

    // Advance one edge, update the reference model, then compare q and tc.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            if (load)
                mq = (int'(d) < N) ? int'(d) : 0;
            else if (en)
                mq = dir_up ? (mq + 1) % N : (mq + N - 1) % N;
        end
        #1;
        check({tag, "_q"}, 32'(q), mq);
        check({tag, "_tc"}, 32'(tc), exp_tc(mq));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mq     = 0;
        reset  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        d      = '0;
        dir_up = 1'b1;

        // Reset held low for 10 ns; the edge at 5 ns must be ignored.
        en = 1'b1;
        #3;
        check("rst_q", 32'(q), 0);
        check("rst_tc", 32'(tc), 0);
        #4;
        check("rst_edge_ignored_q", 32'(q), 0);
        #3;
        reset = 1'b1;
        #1;
        check("release_q", 32'(q), 0);

        // Count 1..9, 0, 1.
        for (int i = 0; i < 11; i++) tick("count");
        check("count_end", 32'(q), 1);

        // Reach 5, then reset between edges.
        for (int i = 0; i < 4; i++) tick("to5");
        check("at5", 32'(q), 5);
        #2;
        reset = 1'b0;
        #1;
        mq = 0;
        check("async_q", 32'(q), 0);
        check("async_tc", 32'(tc), 0);
        load = 1'b1;
        d    = 4'd6;
        tick("held_in_reset");
        load = 1'b0;
        #2;
        reset = 1'b1;
        tick("restart");
        check("restart_is1", 32'(q), 1);

        // Hold at 3 for four edges.
        tick("to3a");
        tick("to3b");
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick("hold");
        check("hold3", 32'(q), 3);
        en = 1'b1;
        tick("resume");
        check("resume4", 32'(q), 4);

        // Load beats enable.
        load = 1'b1;
        d    = 4'd7;
        tick("load7");
        check("load7_lit", 32'(q), 7);
        load = 1'b0;
        tick("after8");
        tick("after9");
        check("tc_at9", 32'(tc), 1);
        tick("after0");
        check("wrap0", 32'(q), 0);

        // Out-of-range and boundary loads.
        tick("pre_oor");
        load = 1'b1;
        d    = 4'd12;
        tick("load12");
        check("load12_lit", 32'(q), 0);
        d = 4'd15;
        tick("load15");
        d = 4'd10;
        tick("load10");
        d = 4'd9;
        tick("load9");
        check("load9_lit", 32'(q), 9);
        check("load9_tc", 32'(tc), 1);
        load = 1'b0;

`ifdef MOD_N_COUNTER_DOWN_EN
        // Down counting through the 0 -> N-1 wrap.
        load = 1'b1;
        d    = 4'd1;
        tick("dn_load1");
        load   = 1'b0;
        dir_up = 1'b0;
        tick("dn0");
        check("dn0_lit", 32'(q), 0);
        check("dn0_tc", 32'(tc), 1);
        tick("dn9");
        check("dn9_lit", 32'(q), 9);
        tick("dn8");
        check("dn8_lit", 32'(q), 8);
        dir_up = 1'b1;
        tick("dn_back_up");
`endif

        // Randomized traffic with occasional mid-cycle async resets.
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            d    = WIDTH'($urandom_range(0, 15));
`ifdef MOD_N_COUNTER_DOWN_EN
            dir_up = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                #1;
                mq = 0;
                check("rand_async_q", 32'(q), 0);
                reset = 1'b1;
            end
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 Parameter N, default 10: modulus; count sequence is 0..N-1; legal range 1..2**WIDTH.
REQ-002 Parameter WIDTH, default 4: width of q and d; 2**WIDTH >= N SHALL hold.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 en  input  1  count enable.
REQ-006 load  input  1  synchronous parallel load strobe.
REQ-007 d  input  WIDTH  load value.
REQ-008 q  output  WIDTH  current count, driven directly from a register.
REQ-009 tc  output  1  terminal count flag, combinational from q.

Function
REQ-010 The counter SHALL use this priority on each rising clk edge while reset=1: load, then en, then hold.
REQ-011 When load=1 and d<N, q SHALL become d on the next edge.
REQ-012 When load=1 and d>=N, q SHALL become 0 on the next edge, so q never leaves 0..N-1.
REQ-013 When load=0 and en=1, q SHALL increment by 1 per edge; q=N-1 SHALL wrap to 0 on the next edge.
REQ-014 When load=0 and en=0, q SHALL hold its value.
REQ-015 tc SHALL be 1 exactly when q==N-1 in up mode, or q==0 in down mode; it is 0 otherwise.
REQ-016 With N=1, q SHALL remain 0 and tc SHALL be constantly 1.
REQ-017 Counter latency SHALL be exactly one clock from an input change to the q update, with no extra pipeline stage.
REQ-018 Arithmetic SHALL be done at WIDTH bits; the wrap SHALL be an explicit compare to N-1, with no reliance on natural overflow.

Reset
REQ-019 When reset=0, q SHALL go to 0 immediately (asynchronously), regardless of clk, en or load; tc then follows REQ-015.
REQ-020 While reset=0, q SHALL stay 0 and all clock edges SHALL be ignored.
REQ-021 Asserting reset mid-count SHALL abandon the current count.
REQ-022 On release (reset 0->1), counting SHALL resume from 0 at the first rising clk edge after release.

Configuration
REQ-023 Macro MOD_N_COUNTER_DOWN_EN SHALL control up/down counting as follows.
REQ-024 When MOD_N_COUNTER_DOWN_EN is defined, an extra input up_dn (1 bit, placed after en) SHALL exist: up_dn=1 counts up per REQ-013; up_dn=0 decrements with wrap 0 -> N-1.
REQ-025 When MOD_N_COUNTER_DOWN_EN is undefined, port up_dn SHALL NOT exist and the block SHALL count up only.
REQ-026 Load and reset behaviour SHALL be identical in both builds.

Verification (N=10, WIDTH=4)
REQ-027 Reset: hold reset=0 for 10 ns, then release with en=1 -> q reads 0,1,...,9,0,1 on successive edges; tc=1 only while q=9.
REQ-028 Async reset: assert reset=0 between edges while q=5 -> q=0 before the next clk edge; after release, counting restarts at 1 on the first edge.
REQ-029 Hold: en=0 at q=3 for 4 edges -> q stays 3; set en=1 -> q=4 on the next edge.
REQ-030 Load: load=1, d=7, en=1 -> q=7 (load wins over en); then q=8,9,0.
REQ-031 Out-of-range load: load=1, d=12 -> q=0; also load=1, d=9 -> q=9 with tc=1.
REQ-032 Down build: define MOD_N_COUNTER_DOWN_EN, set up_dn=0 from q=1 -> q=0 (tc=1), then 9, then 8.
